// File: rtl/fifo_noc2nic_pkg.sv
// Flit encodings, link dimensions and helpers shared by the NoC-to-NIC ejection buffer.
// Build option NOC2NIC_ERROR_CHECK_EN enables the sticky protocol-error flag in fifo_noc2nic.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef N_OF_VC
`define N_OF_VC 3
`endif
`ifndef N_OF_VN
`define N_OF_VN 2
`endif

package fifo_noc2nic_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_TAIL = 2'b01,
    FLIT_HEAD = 2'b10,
    FLIT_HT   = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_e;

  // Bit 0 of the type field marks packet end, bit 1 marks packet start.
  function automatic logic is_tail(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic is_head(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/noc2nic_vc_fifo.sv
// Single-VC flit FIFO, write and read in the same cycle allowed; read data is combinational.
// Writes to a full FIFO and reads from an empty one are ignored.
module noc2nic_vc_fifo
  import fifo_noc2nic_pkg::*;
#(
  parameter int WIDTH = `FLIT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_dat   = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr && !o_full)  r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (i_rd && !o_empty) r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr && !o_full) r_mem[r_wr_ptr[PW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/fifo_noc2nic.sv
// NoC-to-NIC ejection: per-VC flit buffers, round-robin packet-granular streaming, credit/free pulses.
// Tail-to-valid latency 2 cycles; ready_i low freezes the stream; NOC2NIC_ERROR_CHECK_EN enables error_o.
module fifo_noc2nic
  import fifo_noc2nic_pkg::*;
#(
  parameter int N_TOT_OF_VC      = `N_OF_VC*`N_OF_VN,
  parameter int N_FIFO_IN_BUFFER = 4,
  parameter int N_BITS_VC        = clog2(N_TOT_OF_VC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`FLIT_WIDTH-1:0] in_link_i,
  input  logic                   is_valid_i,
  output logic [N_TOT_OF_VC-1:0] credit_signal_o,
  output logic [N_TOT_OF_VC-1:0] free_signal_o,
  output logic [`FLIT_WIDTH-1:0] out_link_o,
  output logic                   is_valid_o,
  input  logic                   ready_i,
  output logic [N_BITS_VC-1:0]   vc_id_o,
  output logic                   error_o
);
  localparam int FW = `FLIT_WIDTH;
  localparam int CW = clog2(N_FIFO_IN_BUFFER + 1);

  logic [1:0]             w_in_type;
  logic [N_BITS_VC-1:0]   w_in_vc;
  logic                   w_in_vc_ok;
  logic                   w_in_full;
  logic [FW-1:0]          w_fifo_dat [N_TOT_OF_VC];
  logic [N_TOT_OF_VC-1:0] w_full, w_empty, w_wr, w_rd, w_inc, w_dec, w_pending;
  logic [CW-1:0]          r_pkt_cnt [N_TOT_OF_VC];
  logic [FW-1:0]          w_head;
  logic                   w_head_tail;
  logic                   w_pop;
  rd_state_e              r_state, w_state_nxt;
  logic [N_BITS_VC-1:0]   r_vc_id, r_last, w_grant_vc;
  logic                   w_grant;
  int                     w_dist, w_best;
  logic [N_TOT_OF_VC-1:0] r_credit, r_free;

  assign w_in_type  = in_link_i[FW-1 -: 2];
  assign w_in_vc    = in_link_i[FW-3 -: N_BITS_VC];
  assign w_in_vc_ok = int'(w_in_vc) < N_TOT_OF_VC;

  always_comb begin
    w_in_full = 1'b0;
    w_head    = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (w_in_vc == N_BITS_VC'(v)) w_in_full = w_full[v];
      if (r_vc_id == N_BITS_VC'(v)) w_head = w_fifo_dat[v];
    end
  end

  assign w_head_tail = is_tail(w_head[FW-1 -: 2]);
  assign w_pop       = (r_state == ST_STREAM) && ready_i;

  for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
    assign w_wr[v]      = is_valid_i && w_in_vc_ok && (w_in_vc == N_BITS_VC'(v)) && !w_full[v];
    assign w_rd[v]      = w_pop && (r_vc_id == N_BITS_VC'(v)) && !w_empty[v];
    assign w_inc[v]     = w_wr[v] && is_tail(w_in_type);
    assign w_dec[v]     = w_rd[v] && w_head_tail;
    assign w_pending[v] = (r_pkt_cnt[v] != '0);

    noc2nic_vc_fifo #(
      .WIDTH (FW),
      .DEPTH (N_FIFO_IN_BUFFER)
    ) u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_wr    (w_wr[v]),
      .i_dat   (in_link_i),
      .i_rd    (w_rd[v]),
      .o_dat   (w_fifo_dat[v]),
      .o_full  (w_full[v]),
      .o_empty (w_empty[v])
    );
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (rst)                      r_pkt_cnt[v] <= '0;
      else if (w_inc[v] && !w_dec[v]) r_pkt_cnt[v] <= r_pkt_cnt[v] + CW'(1);
      else if (!w_inc[v] && w_dec[v]) r_pkt_cnt[v] <= r_pkt_cnt[v] - CW'(1);
    end
  end

  // Round-robin: the pending VC closest after the last grant wins.
  always_comb begin
    w_grant    = 1'b0;
    w_grant_vc = '0;
    w_dist     = 0;
    w_best     = N_TOT_OF_VC;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      w_dist = (v + N_TOT_OF_VC - 1 - int'(r_last)) % N_TOT_OF_VC;
      if (w_pending[v] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_grant    = 1'b1;
        w_grant_vc = N_BITS_VC'(v);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_pop && w_head_tail) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_vc_id  <= '0;
      r_last   <= N_BITS_VC'(N_TOT_OF_VC - 1);
      r_credit <= '0;
      r_free   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_rd;
      r_free   <= w_dec;
      if (r_state == ST_IDLE && w_grant) begin
        r_vc_id <= w_grant_vc;
        r_last  <= w_grant_vc;
      end
    end
  end

  assign is_valid_o      = (r_state == ST_STREAM);
  assign out_link_o      = is_valid_o ? w_head : '0;
  assign vc_id_o         = r_vc_id;
  assign credit_signal_o = r_credit;
  assign free_signal_o   = r_free;

`ifdef NOC2NIC_ERROR_CHECK_EN
  logic [N_TOT_OF_VC-1:0] r_closed;
  logic                   r_err;
  logic                   w_drop, w_bad_head;

  // r_closed[v]: last flit accepted on v ended a packet, so a head is legal next.
  assign w_drop     = is_valid_i && (!w_in_vc_ok || w_in_full);
  assign w_bad_head = is_head(w_in_type) && |(w_wr & ~r_closed);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_closed <= '1;
      r_err    <= 1'b0;
    end else begin
      r_closed <= (r_closed & ~w_wr) | w_inc;
      if (w_drop || w_bad_head) r_err <= 1'b1;
    end
  end

  assign error_o = r_err;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_noc2nic.sv
// Directed bench for fifo_noc2nic: scoreboard of expected output flits plus per-cycle credit/free checks.
module tb_fifo_noc2nic;
  import fifo_noc2nic_pkg::*;

  localparam int NV = `N_OF_VC*`N_OF_VN;
  localparam int FW = `FLIT_WIDTH;
  localparam int NB = clog2(NV);
`ifdef NOC2NIC_ERROR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NB-1:0] vc;
    logic [FW-1:0] flit;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_link_i;
  logic          is_valid_i;
  logic [NV-1:0] credit_signal_o;
  logic [NV-1:0] free_signal_o;
  logic [FW-1:0] out_link_o;
  logic          is_valid_o;
  logic          ready_i;
  logic [NB-1:0] vc_id_o;
  logic          error_o;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [NV-1:0] exp_credit = '0;
  logic [NV-1:0] exp_free   = '0;

  always #5 clk = ~clk;

  fifo_noc2nic dut (
    .clk             (clk),
    .rst             (rst),
    .in_link_i       (in_link_i),
    .is_valid_i      (is_valid_i),
    .credit_signal_o (credit_signal_o),
    .free_signal_o   (free_signal_o),
    .out_link_o      (out_link_o),
    .is_valid_o      (is_valid_o),
    .ready_i         (ready_i),
    .vc_id_o         (vc_id_o),
    .error_o         (error_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int vc, input int pay);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 2]  = t;
    f[FW-3 -: NB] = NB'(vc);
    f[15:0]       = pay[15:0];
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [FW-1:0] f);
    in_link_i  = f;
    is_valid_i = 1'b1;
    step(1);
    is_valid_i = 1'b0;
    in_link_i  = '0;
  endtask

  task automatic expect_out(input logic [FW-1:0] f);
    exp_t e;
    e.vc   = f[FW-3 -: NB];
    e.flit = f;
    sb.push_back(e);
  endtask

  task automatic send_exp(input logic [FW-1:0] f);
    expect_out(f);
    send(f);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      step(1);
      c++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    step(2);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int c;
    c = 0;
    while (is_valid_o !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
    check(tag, 64'(is_valid_o), 64'd1);
  endtask

  // Output monitor: pops the scoreboard on every handshake and predicts next-cycle credit/free.
  always @(negedge clk) begin
    exp_t e;
    check("credit_pulse", 64'(credit_signal_o), 64'(exp_credit));
    check("free_pulse", 64'(free_signal_o), 64'(exp_free));
    exp_credit = '0;
    exp_free   = '0;
    if (rst === 1'b0 && is_valid_o === 1'b1 && ready_i === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_out: observed flit %0h vc %0d expected none", out_link_o, vc_id_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_flit", 64'(out_link_o), 64'(e.flit));
        check("out_vc", 64'(vc_id_o), 64'(e.vc));
        exp_credit = NV'(1) << e.vc;
        exp_free   = e.flit[FW-2] ? exp_credit : '0;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    is_valid_i = 1'b0;
    in_link_i  = '0;
    ready_i    = 1'b0;
    step(2);
    check("rst_valid", 64'(is_valid_o), 64'd0);
    check("rst_link", 64'(out_link_o), 64'd0);
    check("rst_vc", 64'(vc_id_o), 64'd0);
    check("rst_credit", 64'(credit_signal_o), 64'd0);
    check("rst_free", 64'(free_signal_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    rst = 1'b0;
    step(1);

    // Single head-tail on VC2: two-cycle latency, then credit and free on bit 2.
    ready_i = 1'b1;
    send_exp(mk(FLIT_HT, 2, 'h0211));
    check("ht_not_yet_valid", 64'(is_valid_o), 64'd0);
    step(1);
    check("ht_valid", 64'(is_valid_o), 64'd1);
    check("ht_vc", 64'(vc_id_o), 64'd2);
    step(1);
    check("ht_credit", 64'(credit_signal_o), 64'b000100);
    check("ht_free", 64'(free_signal_o), 64'b000100);
    check("ht_done", 64'(is_valid_o), 64'd0);
    step(2);

    // Four-flit packet on VC0 streams on consecutive cycles.
    send_exp(mk(FLIT_HEAD, 0, 'h0001));
    send_exp(mk(FLIT_BODY, 0, 'h0002));
    send_exp(mk(FLIT_BODY, 0, 'h0003));
    send_exp(mk(FLIT_TAIL, 0, 'h0004));
    wait_valid(10, "pkt4_start");
    for (int k = 0; k < 4; k++) begin
      check("pkt4_burst", 64'(is_valid_o), 64'd1);
      step(1);
    end
    check("pkt4_end", 64'(is_valid_o), 64'd0);
    wait_drain(10, "pkt4_drain");

    // Back-to-back head-tails on VC0: same-cycle write/pop and pointer wrap.
    for (int k = 0; k < 6; k++) send_exp(mk(FLIT_HT, 0, 'h0100 + k));
    wait_drain(40, "wrap_drain");

    // Stall three cycles mid-packet on VC4.
    ready_i = 1'b0;
    send_exp(mk(FLIT_HEAD, 4, 'h0041));
    send_exp(mk(FLIT_BODY, 4, 'h0042));
    send_exp(mk(FLIT_TAIL, 4, 'h0043));
    wait_valid(10, "stall_start");
    check("stall_head", 64'(out_link_o), 64'(mk(FLIT_HEAD, 4, 'h0041)));
    ready_i = 1'b1;
    step(1);
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_link", 64'(out_link_o), 64'(mk(FLIT_BODY, 4, 'h0042)));
      check("stall_vc", 64'(vc_id_o), 64'd4);
      check("stall_valid", 64'(is_valid_o), 64'd1);
      if (k > 0) check("stall_no_credit", 64'(credit_signal_o), 64'd0);
      step(1);
    end
    ready_i = 1'b1;
    wait_drain(10, "stall_drain");

    // Round robin: after VC0, pending VC1/VC3 go VC1 first; after VC2, VC3 first.
    ready_i = 1'b0;
    send(mk(FLIT_HT, 0, 'h0050));
    send(mk(FLIT_HT, 3, 'h0053));
    send(mk(FLIT_HT, 1, 'h0051));
    expect_out(mk(FLIT_HT, 0, 'h0050));
    expect_out(mk(FLIT_HT, 1, 'h0051));
    expect_out(mk(FLIT_HT, 3, 'h0053));
    ready_i = 1'b1;
    wait_drain(20, "rr1_drain");
    ready_i = 1'b0;
    send(mk(FLIT_HT, 2, 'h0062));
    send(mk(FLIT_HT, 1, 'h0061));
    send(mk(FLIT_HT, 3, 'h0063));
    expect_out(mk(FLIT_HT, 2, 'h0062));
    expect_out(mk(FLIT_HT, 3, 'h0063));
    expect_out(mk(FLIT_HT, 1, 'h0061));
    ready_i = 1'b1;
    wait_drain(20, "rr2_drain");

    // Out-of-range VC ids are dropped.
    send(mk(FLIT_HT, 6, 'h0066));
    send(mk(FLIT_HT, 7, 'h0077));
    for (int k = 0; k < 4; k++) begin
      check("badvc_no_out", 64'(is_valid_o), 64'd0);
      step(1);
    end
    check("badvc_error", 64'(error_o), 64'(ERR_EN));
    rst = 1'b1;
    step(1);
    check("error_cleared", 64'(error_o), 64'd0);
    rst = 1'b0;
    step(1);

    // Head following a non-tail on the same VC.
    ready_i = 1'b0;
    send_exp(mk(FLIT_HEAD, 5, 'h0051));
    send_exp(mk(FLIT_HEAD, 5, 'h0052));
    check("head_head_error", 64'(error_o), 64'(ERR_EN));
    send_exp(mk(FLIT_TAIL, 5, 'h0053));
    ready_i = 1'b1;
    wait_drain(20, "head_head_drain");

    // Reset mid-stream discards the packet; VC0 served normally afterwards.
    ready_i = 1'b0;
    send(mk(FLIT_HEAD, 5, 'h0071));
    send(mk(FLIT_TAIL, 5, 'h0072));
    wait_valid(10, "mid_rst_start");
    check("mid_rst_vc", 64'(vc_id_o), 64'd5);
    rst = 1'b1;
    sb.delete();
    step(1);
    check("mid_rst_valid", 64'(is_valid_o), 64'd0);
    check("mid_rst_link", 64'(out_link_o), 64'd0);
    check("mid_rst_vc0", 64'(vc_id_o), 64'd0);
    check("mid_rst_credit", 64'(credit_signal_o), 64'd0);
    check("mid_rst_free", 64'(free_signal_o), 64'd0);
    check("mid_rst_error", 64'(error_o), 64'd0);
    rst     = 1'b0;
    ready_i = 1'b1;
    step(1);
    send_exp(mk(FLIT_HT, 0, 'h0080));
    step(1);
    check("post_rst_vc", 64'(vc_id_o), 64'd0);
    wait_drain(10, "post_rst_drain");
    for (int k = 0; k < 3; k++) begin
      check("post_rst_flushed", 64'(is_valid_o), 64'd0);
      step(1);
    end

    // Overflow: fifth flit into a full depth-4 VC0 buffer is dropped.
    ready_i = 1'b0;
    send_exp(mk(FLIT_HEAD, 0, 'h0091));
    send_exp(mk(FLIT_BODY, 0, 'h0092));
    send_exp(mk(FLIT_BODY, 0, 'h0093));
    send_exp(mk(FLIT_TAIL, 0, 'h0094));
    send(mk(FLIT_HT, 0, 'h0099));
    check("ovf_error", 64'(error_o), 64'(ERR_EN));
    ready_i = 1'b1;
    wait_drain(20, "ovf_drain");
    for (int k = 0; k < 4; k++) begin
      check("ovf_dropped", 64'(is_valid_o), 64'd0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
